// File: rtl/vga_framebuffer.sv
// vga_framebuffer: 640x480@60 VGA timing that scans out a 128x128 RGB444 framebuffer
// in the top-left corner; the framebuffer is written through an AXI-stream command port.
module vga_framebuffer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        cmd_axis_tvalid_i,
  output logic        cmd_axis_tready_o,
  input  logic [31:0] cmd_axis_tdata_i,
  output logic        vga_hsync_o,
  output logic        vga_vsync_o,
  output logic [3:0]  vga_r_o,
  output logic [3:0]  vga_g_o,
  output logic [3:0]  vga_b_o
);
  localparam logic [9:0] H_MAX = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_MAX = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  logic [9:0]  r_sx, r_sy;
  logic        r_ready, r_clr;
  logic [13:0] r_ptr, r_clr_addr;
  logic [15:0] r_clr_data;
  logic [15:0] r_vram [16384];
  logic [15:0] r_rd;
  logic        r_de1, r_fb1, r_hs1, r_vs1;
  logic        w_de, w_fb, w_hs, w_vs, w_acc, w_we;
  logic [3:0]  w_op;
  logic [13:0] w_wa, w_ra;
  logic [15:0] w_wd;
  logic        w_unused;
  assign w_de = (r_sx < H_ACT) && (r_sy < V_ACT);
  assign w_fb = (r_sx[9:7] == 3'd0) && (r_sy[9:7] == 3'd0);
  assign w_hs = !((r_sx >= HS_BEG) && (r_sx < HS_END));
  assign w_vs = !((r_sy >= VS_BEG) && (r_sy < VS_END));
  assign w_ra = {r_sy[6:0], r_sx[6:0]};
  assign w_op = cmd_axis_tdata_i[31:28];
  assign w_acc = cmd_axis_tvalid_i && r_ready;
  // A running CLEAR owns the write port; tready is low then, so no command can collide.
  assign w_we = r_clr || (w_acc && w_op == 4'h2);
  assign w_wa = r_clr ? r_clr_addr : r_ptr;
  assign w_wd = r_clr ? r_clr_data : cmd_axis_tdata_i[15:0];
  assign cmd_axis_tready_o = r_ready;
  assign w_unused = ^{cmd_axis_tdata_i[27:16], r_rd[15:12]};
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_sx <= '0;
      r_sy <= '0;
    end else begin
      r_sx <= (r_sx == H_MAX) ? 10'd0 : r_sx + 10'd1;
      if (r_sx == H_MAX) r_sy <= (r_sy == V_MAX) ? 10'd0 : r_sy + 10'd1;
    end
  end
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_ready <= 1'b0;
      r_clr <= 1'b0;
      r_ptr <= '0;
      r_clr_addr <= '0;
      r_clr_data <= '0;
    end else if (r_clr) begin
      r_clr_addr <= r_clr_addr + 14'd1;
      if (&r_clr_addr) begin
        r_clr <= 1'b0;
        r_ready <= 1'b1;
      end
    end else if (w_acc && w_op == 4'h3) begin
      r_clr <= 1'b1;
      r_ready <= 1'b0;
      r_clr_addr <= '0;
      r_clr_data <= cmd_axis_tdata_i[15:0];
    end else begin
      r_ready <= 1'b1;
      if (w_acc && w_op == 4'h1) r_ptr <= cmd_axis_tdata_i[13:0];
      if (w_acc && w_op == 4'h2) r_ptr <= r_ptr + 14'd1;
    end
  end
  // Read-before-write: a same-cycle read of the written address sees the old word.
  always_ff @(posedge clk) begin
    if (w_we) r_vram[w_wa] <= w_wd;
    r_rd <= r_vram[w_ra];
  end
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_de1 <= 1'b0;
      r_fb1 <= 1'b0;
      r_hs1 <= 1'b1;
      r_vs1 <= 1'b1;
      vga_hsync_o <= 1'b1;
      vga_vsync_o <= 1'b1;
      vga_r_o <= '0;
      vga_g_o <= '0;
      vga_b_o <= '0;
    end else begin
      r_de1 <= w_de;
      r_fb1 <= w_fb;
      r_hs1 <= w_hs;
      r_vs1 <= w_vs;
      vga_hsync_o <= r_hs1;
      vga_vsync_o <= r_vs1;
      vga_r_o <= !r_de1 ? 4'h0 : r_fb1 ? r_rd[11:8] : 4'h1;
      vga_g_o <= !r_de1 ? 4'h0 : r_fb1 ? r_rd[7:4] : 4'h1;
      vga_b_o <= !r_de1 ? 4'h0 : r_fb1 ? r_rd[3:0] : 4'h1;
    end
  end
endmodule

// File: tb/tb_vga_framebuffer.sv
// tb_vga_framebuffer: random command traffic checked every pixel clock against a
// behavioural screen/VRAM model derived from the display rules.
module tb_vga_framebuffer;
  logic clk = 1'b0, rst = 1'b0, vld = 1'b0, rdy, hs, vs;
  logic [31:0] dat = '0;
  logic [3:0] r, g, b;
  int n_tests = 0, n_fail = 0;
  vga_framebuffer dut (
    .clk(clk), .reset_i(rst),
    .cmd_axis_tvalid_i(vld), .cmd_axis_tready_o(rdy), .cmd_axis_tdata_i(dat),
    .vga_hsync_o(hs), .vga_vsync_o(vs), .vga_r_o(r), .vga_g_o(g), .vga_b_o(b)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  // Model: VRAM contents with known-valid flags, screen position from clock count.
  logic [15:0] m [16384];
  bit v [16384];
  int n, clr_e;
  logic [13:0] ptr;
  logic [15:0] cdat;
  logic exp_rdy;
  logic [13:0] exp_px, nxt_px;
  bit exp_ok, nxt_ok, acc;
  function automatic logic [13:0] pix(input int p, output bit ok);
    int x, y;
    logic [11:0] c;
    logic [15:0] w;
    x = p % 800;
    y = (p / 800) % 525;
    ok = 1'b1;
    c = 12'h000;
    if (x < 640 && y < 480) begin
      if (x < 128 && y < 128) begin
        w = m[14'(y * 128 + x)];
        c = w[11:0];
        ok = v[14'(y * 128 + x)];
      end else c = 12'h111;
    end
    return {c, !(x >= 656 && x < 752), !(y >= 490 && y < 492)};
  endfunction
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      n = 0; clr_e = -1; ptr = '0; exp_rdy = 1'b0;
      exp_px = 14'h3; nxt_px = 14'h3; exp_ok = 1'b1; nxt_ok = 1'b1;
    end else begin
      n++;
      exp_px = nxt_px;
      exp_ok = nxt_ok;
      nxt_px = pix(n - 1, nxt_ok);
      acc = vld && exp_rdy;
      if (clr_e >= 0 && n > clr_e && n <= clr_e + 16384) begin
        m[14'(n - clr_e - 1)] = cdat;
        v[14'(n - clr_e - 1)] = 1'b1;
      end
      if (acc) begin
        case (dat[31:28])
          4'h1: ptr = dat[13:0];
          4'h2: begin m[ptr] = dat[15:0]; v[ptr] = 1'b1; ptr = ptr + 14'd1; end
          4'h3: begin clr_e = n; cdat = dat[15:0]; end
          default: ;
        endcase
      end
      exp_rdy = !(clr_e >= 0 && n >= clr_e && n < clr_e + 16384);
    end
  end
  initial forever begin
    @(negedge clk);
    chk("pix", exp_ok ? {r, g, b, hs, vs} : {12'h0, hs, vs},
        exp_ok ? exp_px : {12'h0, exp_px[1:0]});
    chk("rdy", rdy, exp_rdy);
  end
  task automatic send(input logic [31:0] d);
    int k = 0;
    vld = 1'b1;
    dat = d;
    while (!rdy && k < 20000) begin k++; @(negedge clk); end
    chk("send_rdy", rdy, 1);
    @(negedge clk);
    vld = 1'b0;
  endtask
  task automatic rand_cmds(input int cnt);
    logic [31:0] d;
    for (int i = 0; i < cnt; i++) begin
      d = $urandom();
      case ($urandom_range(0, 5))
        0: d[31:28] = 4'h1;
        1, 2, 3: d[31:28] = 4'h2;
        4: d[31:28] = 4'hF;
        default: d[31:28] = 4'h0;
      endcase
      send(d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask
  initial begin
    int c, lo;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rgb", {r, g, b}, 0);
    chk("rst_sync", {hs, vs}, 2'b11);
    chk("rst_rdy", rdy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_rise", rdy, 1);
    send(32'h1000_0200);
    send(32'h3000_0777);
    vld = 1'b1;
    dat = 32'h2000_0ABC;
    c = 0;
    while (!rdy && c < 20000) begin c++; @(negedge clk); end
    chk("clr_len", c, 16384);
    @(negedge clk);
    vld = 1'b0;
    send(32'h1000_0081);
    send(32'h2000_0F0A);
    send(32'h1000_3FFF);
    send(32'h2000_0123);
    send(32'h2000_0456);
    send(32'hF000_0999);
    rand_cmds(150);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_rgb", {r, g, b}, 0);
    chk("arst_sync", {hs, vs}, 2'b11);
    chk("arst_rdy", rdy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    c = 0;
    do begin @(negedge clk); c++; end while (hs && c < 2000);
    chk("hs_fall", c, 658);
    lo = 0;
    while (!hs && lo < 2000) begin lo++; @(negedge clk); end
    chk("hs_low", lo, 96);
    c = 0;
    while (hs && c < 2000) begin c++; @(negedge clk); end
    chk("hs_period", lo + c, 800);
    rand_cmds(150);
    repeat (62000) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
